// File: rtl/apu_pkg.sv
// -----------------------------------------------------------------------------
// apu_pkg
// Shared constants for the 2A03 audio channel gating logic.
//   LIN_W      : width of the triangle linear counter and its reload value
//   LEN_W      : width of the length counters (triangle, pulse, noise)
//   LEN_TABLE  : 32-entry length lookup, indexed by the 5-bit length index
//                written to the channel's fourth register
//   len_lookup : helper returning LEN_TABLE[idx]
// -----------------------------------------------------------------------------
package apu_pkg;

   localparam int LIN_W = 7;
   localparam int LEN_W = 8;

   // Index 0 is the leftmost element.
   localparam logic [0:31][LEN_W-1:0] LEN_TABLE = {
      8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
      8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
      8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
      8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
   };

   function automatic logic [LEN_W-1:0] len_lookup(input logic [4:0] idx);
      return LEN_TABLE[idx];
   endfunction

endpackage

// File: rtl/tri_lin_len_ctrl_if.sv
// -----------------------------------------------------------------------------
// tri_lin_len_ctrl_if
// Register-write / frame-tick bus into the triangle gating stage and its
// status outputs.
//   slave  modport : the gating stage (consumes strobes, drives status)
//   master modport : CPU / frame sequencer side
// Signals:
//   wr_4008, wr_400b        one-cycle register write strobes
//   r1, r4                  $4008 / $400B data bytes
//   period                  11-bit timer period
//   chan_en                 channel enable level from $4015
//   quarter_frame, half_frame one-cycle frame-sequencer ticks
//   step_en, len_active     gating outputs
//   lin_cnt, len_cnt        debug counter views
// -----------------------------------------------------------------------------
interface tri_lin_len_ctrl_if;
   import apu_pkg::*;

   logic             wr_4008;
   logic             wr_400b;
   logic [7:0]       r1;
   logic [7:0]       r4;
   logic [10:0]      period;
   logic             chan_en;
   logic             quarter_frame;
   logic             half_frame;
   logic             step_en;
   logic             len_active;
   logic [LIN_W-1:0] lin_cnt;
   logic [LEN_W-1:0] len_cnt;

   modport slave (
      input  wr_4008, wr_400b, r1, r4, period, chan_en, quarter_frame, half_frame,
      output step_en, len_active, lin_cnt, len_cnt
   );

   modport master (
      output wr_4008, wr_400b, r1, r4, period, chan_en, quarter_frame, half_frame,
      input  step_en, len_active, lin_cnt, len_cnt
   );

endinterface

// File: rtl/apu_len_counter.sv
// -----------------------------------------------------------------------------
// apu_len_counter
// Channel length counter shared by the triangle, pulse and noise channels.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   load_i      length register write strobe
//   idx_i       5-bit length index from the written register
//   halt_i      halt (length-counter disable) flag
//   tick_i      half-frame tick
//   en_i        channel enable level; low forces the counter to zero
//   cnt_o       current count
//   active_o    count is non-zero
// Same-cycle priority: enable clear > load > tick decrement.
// -----------------------------------------------------------------------------
module apu_len_counter
   import apu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [4:0]       idx_i,
   input  logic             halt_i,
   input  logic             tick_i,
   input  logic             en_i,
   output logic [LEN_W-1:0] cnt_o,
   output logic             active_o
);

   logic [LEN_W-1:0] cnt_q, cnt_d;

   // NOTE: cnt_d is given its hold value first so every path assigns it and
   // no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = len_lookup(idx_i);
      end else if (tick_i && !halt_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - LEN_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign active_o = (cnt_q != '0);

endmodule

// File: rtl/tri_lin_len_ctrl.sv
// -----------------------------------------------------------------------------
// tri_lin_len_ctrl
// Triangle channel gating stage: linear counter plus length counter. The
// waveform generator may only advance its 32-step sequence while step_en is
// high; otherwise the output level freezes.
// Ports:
//   clk    CPU-rate clock
//   reset  synchronous, active-high; clears all state
//   bus    tri_lin_len_ctrl_if.slave (write strobes, data, frame ticks,
//          channel enable, step_en / len_active / debug counters)
// Build option:
//   TRI_ULTRASONIC_MUTE_EN  when defined, step_en also requires period >= 2,
//                           freezing the waveform at ultrasonic periods 0/1.
//                           When undefined, period is ignored.
// -----------------------------------------------------------------------------
module tri_lin_len_ctrl
   import apu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   tri_lin_len_ctrl_if.slave  bus
);

   logic             ctrl_q,       ctrl_d;
   logic [LIN_W-1:0] reload_val_q, reload_val_d;
   logic             reload_flag_q, reload_flag_d;
   logic [LIN_W-1:0] lin_q,        lin_d;

   logic [LEN_W-1:0] len_cnt;
   logic             len_nz;

   always_comb begin
      ctrl_d        = ctrl_q;
      reload_val_d  = reload_val_q;
      reload_flag_d = reload_flag_q;
      lin_d         = lin_q;

      if (bus.wr_4008) begin
         ctrl_d       = bus.r1[7];
         reload_val_d = bus.r1[LIN_W-1:0];
      end

      // The quarter tick acts on the pre-write flag; a same-cycle $400B write
      // then overrides the clear so the next tick reloads.
      if (bus.quarter_frame) begin
         if (reload_flag_q) begin
            lin_d = reload_val_q;
         end else if (lin_q != '0) begin
            lin_d = lin_q - LIN_W'(1);
         end
         if (!ctrl_q) begin
            reload_flag_d = 1'b0;
         end
      end
      if (bus.wr_400b) begin
         reload_flag_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q        <= 1'b0;
         reload_val_q  <= '0;
         reload_flag_q <= 1'b0;
         lin_q         <= '0;
      end else begin
         ctrl_q        <= ctrl_d;
         reload_val_q  <= reload_val_d;
         reload_flag_q <= reload_flag_d;
         lin_q         <= lin_d;
      end
   end

   // The control flag doubles as the length-counter halt.
   apu_len_counter u_len (
      .clk      (clk),
      .reset    (reset),
      .load_i   (bus.wr_400b),
      .idx_i    (bus.r4[7:3]),
      .halt_i   (ctrl_q),
      .tick_i   (bus.half_frame),
      .en_i     (bus.chan_en),
      .cnt_o    (len_cnt),
      .active_o (len_nz)
   );

`ifdef TRI_ULTRASONIC_MUTE_EN
   assign bus.step_en = (lin_q != '0) && len_nz && (bus.period >= 11'd2);
   logic unused_bits;
   assign unused_bits = ^bus.r4[2:0];
`else
   assign bus.step_en = (lin_q != '0) && len_nz;
   logic unused_bits;
   assign unused_bits = ^{bus.r4[2:0], bus.period};
`endif

   assign bus.len_active = len_nz;
   assign bus.lin_cnt    = lin_q;
   assign bus.len_cnt    = len_cnt;

endmodule

// File: tb/tb_tri_lin_len_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tri_lin_len_ctrl
// Directed bench for tri_lin_len_ctrl. Each step drives the inputs for one
// clock, queues the expected counter/status values, and after the edge pops
// and compares them against the DUT outputs.
// Honours TRI_ULTRASONIC_MUTE_EN when computing expected step_en.
// -----------------------------------------------------------------------------
module tb_tri_lin_len_ctrl;

   logic clk = 1'b0;
   logic reset;

   tri_lin_len_ctrl_if bus ();

   tri_lin_len_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [6:0] lin;
      logic [7:0] len;
      logic       step;
      logic       active;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check_pop();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_empty observed=0 entries required=1");
         return;
      end
      e = sb.pop_front();
      total++;
      assert (bus.lin_cnt === e.lin) else begin
         bad++;
         $error("FAIL %s lin_cnt observed=%0d expected=%0d", e.tag, bus.lin_cnt, e.lin);
      end
      total++;
      assert (bus.len_cnt === e.len) else begin
         bad++;
         $error("FAIL %s len_cnt observed=%0d expected=%0d", e.tag, bus.len_cnt, e.len);
      end
      total++;
      assert (bus.step_en === e.step) else begin
         bad++;
         $error("FAIL %s step_en observed=%0b expected=%0b", e.tag, bus.step_en, e.step);
      end
      total++;
      assert (bus.len_active === e.active) else begin
         bad++;
         $error("FAIL %s len_active observed=%0b expected=%0b", e.tag, bus.len_active, e.active);
      end
   endtask

   // Queue the expectation for the current inputs, run one clock, compare.
   task automatic cyc(input string tag, input int lin, input int len);
      exp_t e;
      e.tag    = tag;
      e.lin    = 7'(lin);
      e.len    = 8'(len);
      e.step   = (lin != 0) && (len != 0);
`ifdef TRI_ULTRASONIC_MUTE_EN
      e.step   = e.step && (bus.period >= 11'd2);
`endif
      e.active = (len != 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.wr_4008       = 1'b0;
      bus.wr_400b       = 1'b0;
      bus.quarter_frame = 1'b0;
      bus.half_frame    = 1'b0;
      check_pop();
   endtask

   task automatic w4008(input logic [7:0] d);
      bus.wr_4008 = 1'b1;
      bus.r1      = d;
   endtask

   task automatic w400b(input logic [4:0] idx);
      bus.wr_400b = 1'b1;
      bus.r4      = {idx, 3'b101};
   endtask

   initial begin
      reset             = 1'b1;
      bus.wr_4008       = 1'b0;
      bus.wr_400b       = 1'b0;
      bus.r1            = 8'h00;
      bus.r4            = 8'h00;
      bus.period        = 11'd100;
      bus.chan_en       = 1'b0;
      bus.quarter_frame = 1'b0;
      bus.half_frame    = 1'b0;

      cyc("reset0", 0, 0);
      cyc("reset1", 0, 0);
      reset       = 1'b0;
      bus.chan_en = 1'b1;

      // Basic load and linear countdown.
      w4008(8'h05);               cyc("wr4008_05", 0, 0);
      w400b(5'd1);                cyc("load_idx1", 0, 254);
      bus.quarter_frame = 1'b1;   cyc("qf_reload", 5, 254);
      for (int i = 1; i <= 5; i++) begin
         bus.quarter_frame = 1'b1;
         cyc($sformatf("qf_dec%0d", i), 5 - i, 254);
      end
      bus.quarter_frame = 1'b1;   cyc("qf_zero_hold", 0, 254);

      // Control flag set: length halted, linear reload every quarter.
      w4008(8'h83);               cyc("wr4008_83", 0, 254);
      w400b(5'd0);                cyc("load_idx0", 0, 10);
      for (int i = 0; i < 10; i++) begin
         bus.quarter_frame = 1'b1;
         bus.half_frame    = 1'b1;
         cyc($sformatf("halt%0d", i), 3, 10);
      end

      // Channel disable clears and blocks loads.
      w4008(8'h00);               cyc("wr4008_00", 3, 10);
      w400b(5'd2);                cyc("load_idx2", 3, 20);
      bus.chan_en = 1'b0;         cyc("disable_clr", 3, 0);
      w400b(5'd1);                cyc("load_while_dis", 3, 0);
      bus.chan_en = 1'b1;         cyc("reenable", 3, 0);

      // Load beats half-frame decrement in the same cycle.
      w400b(5'd9);                cyc("load_idx9", 3, 8);
      bus.half_frame = 1'b1;      cyc("hf_dec_7", 3, 7);
      w400b(5'd2);
      bus.half_frame = 1'b1;      cyc("load_vs_hf", 3, 20);

      // Write + quarter in one cycle: decrement uses old flag, flag ends set.
      w4008(8'h04);               cyc("wr4008_04", 3, 20);
      bus.quarter_frame = 1'b1;   cyc("qf_reload4", 4, 20);
      w400b(5'd2);
      bus.quarter_frame = 1'b1;   cyc("load_vs_qf", 3, 20);
      bus.quarter_frame = 1'b1;   cyc("qf_flag_set", 4, 20);

      // Length decrement to zero without wrap.
      w400b(5'd3);                cyc("load_idx3", 4, 2);
      bus.half_frame = 1'b1;      cyc("hf_to1", 4, 1);
      bus.half_frame = 1'b1;      cyc("hf_to0", 4, 0);
      bus.half_frame = 1'b1;      cyc("hf_hold0a", 4, 0);
      bus.half_frame = 1'b1;      cyc("hf_hold0b", 4, 0);

      // Period gating (only affects step_en with the mute option).
      w400b(5'd1);                cyc("load_idx1b", 4, 254);
      bus.period = 11'd1;         cyc("period1", 4, 254);
      bus.period = 11'd0;         cyc("period0", 4, 254);
      bus.period = 11'd2;         cyc("period2", 4, 254);
      bus.period = 11'd100;

      // Reset mid-operation wins over strobes.
      reset = 1'b1;
      w400b(5'd1);
      bus.quarter_frame = 1'b1;
      bus.half_frame    = 1'b1;   cyc("reset_mid", 0, 0);
      reset = 1'b0;               cyc("post_reset", 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
